spike_char_decoder: RTL and testbench
=====================================

Name: spike_char_decoder

Overview:
Downstream stage of the hnsn_top recurrent layer. Consumes the 4-bit recurrent spike vector and counts spikes per neuron over fixed time windows. Each window is classified into an activity code, debounced over consecutive windows, and mapped to an ASCII character with valid and changed strobes. It is the dedicated char_out/char_valid/char_changed generator for the chip's readout path.

Parameters:
WIN_LEN, 16, cycles per observation window (2..255)
CNT_W, 5, per-neuron spike counter width; counters saturate at 2^CNT_W-1
FIRE_TH, 4, minimum window spike count for a neuron to count as active
STABLE_N, 2, consecutive identical window codes required before a commit (1..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
spike_in  input  4  recurrent-layer spikes, bit i = neuron i, sampled every enabled cycle
enable  input  1  decoder run; 0 aborts and holds the decoder
char_out  output  8  committed ASCII character
char_valid  output  1  char_out holds a live (non-idle) decode
char_changed  output  1  one-cycle pulse when a commit changes the character or revalidates it
active_mask  output  4  thresholded mask of the last completed window
win_done  output  1  one-cycle pulse after each completed window

Behaviour:
- Reset (async, any time, including mid-window): w_cnt=0, all counters=0, last_code=0, stab=0, char_out=0x00, char_valid=0, char_changed=0, active_mask=0, win_done=0, state=HOLD.
- States: HOLD (enable=0) and COUNT (enable=1). HOLD->COUNT on the first edge with enable=1; that edge is window cycle 0. COUNT->HOLD on any edge with enable=0.
- HOLD behaviour: w_cnt and counters are cleared, and the partial window is discarded with no win_done. char_out, char_valid, active_mask, last_code and stab are held. Strobes are 0.
- COUNT behaviour: on each edge, cnt[i] = sat(cnt[i] + spike_in[i]) and w_cnt increments.
- Closing edge (w_cnt==WIN_LEN-1):
  - Each final count includes that edge's spike.
  - mask[i] = (final cnt[i] >= FIRE_TH). Register mask to active_mask.
  - win_done=1 for the following cycle.
  - Counters and w_cnt return to 0, so the next edge is cycle 0 of the next window. There are no gap cycles.
- Code map (mask -> char):
  - 0011->'A' 0x41; 1100->'B' 0x42; 0101->'C' 0x43; 1010->'D' 0x44; 1111->'X' 0x58
  - 0000->IDLE
  - any other mask->'?' 0x3F
- Debounce, evaluated on the closing edge:
  - If the code equals last_code, stab = min(stab+1, STABLE_N); otherwise stab = 1.
  - last_code is then updated to the code.
- Commit whenever the new stab==STABLE_N, on the same closing edge:
  - Non-IDLE code: char_out=char and char_valid=1. char_changed=1 next cycle if char differs from the old char_out or the old char_valid was 0.
  - IDLE code: char_valid=0, char_out holds its value, no char_changed pulse.
  - A repeated identical commit produces no pulse.
- Latency: outputs update on the closing edge of the STABLE_N-th consecutive matching window. The strobes are high for exactly the one cycle after that edge.
- Counter saturation: a neuron spiking every cycle with WIN_LEN > 2^CNT_W-1 saturates its counter and still classifies as active.

Optional Feature:
SPIKE_DEC_STATS_EN:
- When defined, adds output commit_cnt[15:0]. It increments on every commit that pulses char_changed, saturates at 0xFFFF, resets to 0, and is held in HOLD.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset check: assert rst_n=0 mid-window with spikes active -> every output is 0 immediately (asynchronously). After release, the first window completes 16 enabled cycles later.
2. spike_in=0011 for 32 cycles with enable=1 -> win_done pulses after edges 16 and 32. char_out=0x41 and char_valid=1 after edge 32. char_changed pulses once. active_mask=0011.
3. Continue with 1100 for 32 cycles -> the first window gives stab=1 and no change; after the second window char_out=0x42 with one char_changed pulse. A further 16 cycles of 1100 -> no pulse.
4. spike_in=0001 for 32 cycles -> char_out=0x3F and char_valid=1. Then 0011 asserted only on window cycles 0,6,12 (3 spikes <4) for two windows -> active_mask=0000, char_valid=0, char_out stays 0x3F, no pulse.
5. Drop enable after 10 cycles of 1111, hold for 5 cycles, then re-enable with 1111 -> no win_done during the abort. The next win_done comes 16 enabled cycles after re-enable. 'X' commits after two full windows.
6. Set STABLE_N=1 and alternate 0011/0101 each window -> a commit and char_changed on every window: 0x41, 0x43, 0x41. With SPIKE_DEC_STATS_EN defined, commit_cnt=3.

Source files
------------

// File: rtl/spike_char_decoder_if.sv
// spike_char_decoder_if: spike input / character readout bundle for spike_char_decoder.
// Optional build macro: SPIKE_DEC_STATS_EN adds the commit_cnt output.
interface spike_char_decoder_if;
  logic [3:0]  spike_in;
  logic        enable;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_changed;
  logic [3:0]  active_mask;
  logic        win_done;
`ifdef SPIKE_DEC_STATS_EN
  logic [15:0] commit_cnt;

  modport slave (
    input  spike_in, enable,
    output char_out, char_valid, char_changed, active_mask, win_done, commit_cnt
  );
  modport master (
    output spike_in, enable,
    input  char_out, char_valid, char_changed, active_mask, win_done, commit_cnt
  );
`else
  modport slave (
    input  spike_in, enable,
    output char_out, char_valid, char_changed, active_mask, win_done
  );
  modport master (
    output spike_in, enable,
    input  char_out, char_valid, char_changed, active_mask, win_done
  );
`endif
endinterface

// File: rtl/spike_char_decoder.sv
// spike_char_decoder: windowed per-neuron spike counting, thresholding, debounce
// and ASCII character commit for the recurrent-layer readout path.
// Optional build macro: SPIKE_DEC_STATS_EN adds a saturating 16-bit commit counter.
//
// state | meaning
// HOLD  | enable low: window discarded, committed outputs frozen
// COUNT | enable high: accumulating spikes, closing a window every WIN_LEN edges
module spike_char_decoder #(
  parameter int WIN_LEN  = 16,
  parameter int CNT_W    = 5,
  parameter int FIRE_TH  = 4,
  parameter int STABLE_N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spike_char_decoder_if.slave  bus
);

  typedef enum logic {HOLD, COUNT} state_t;
  typedef enum logic [2:0] {C_IDLE, C_A, C_B, C_C, C_D, C_X, C_Q} code_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TH       = CNT_W'(FIRE_TH);
  localparam logic [7:0]       LAST_CYC = 8'(WIN_LEN - 1);
  localparam logic [2:0]       STAB_MAX = 3'(STABLE_N);

  state_t                  state_q, state_d;
  logic                    run;
  logic [7:0]              w_cnt_q;
  logic [3:0][CNT_W-1:0]   cnt_q, cnt_inc;
  logic [3:0]              mask;
  code_t                   code, last_code_q;
  logic [7:0]              ch;
  logic [2:0]              stab_q, stab_new;
  logic                    closing, commit, chg;

  logic [7:0]              char_out_q;
  logic                    char_valid_q, char_changed_q, win_done_q;
  logic [3:0]              active_mask_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HOLD;
    else        state_q <= state_d;
  end

  // Next-state logic; the edge that enters COUNT already counts as window cycle 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (bus.enable)  state_d = COUNT;
      COUNT:   if (!bus.enable) state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  assign run = (state_d == COUNT);

  // Saturating increment and threshold, including this edge's spike
  always_comb begin
    cnt_inc = '0;
    mask    = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(bus.spike_in[i]);
      mask[i]    = (cnt_inc[i] >= TH);
    end
  end

  // Mask to activity code and character
  always_comb begin
    code = C_Q;
    ch   = 8'h3F;
    case (mask)
      4'b0000: begin code = C_IDLE; ch = 8'h00; end
      4'b0011: begin code = C_A;    ch = 8'h41; end
      4'b1100: begin code = C_B;    ch = 8'h42; end
      4'b0101: begin code = C_C;    ch = 8'h43; end
      4'b1010: begin code = C_D;    ch = 8'h44; end
      4'b1111: begin code = C_X;    ch = 8'h58; end
      default: begin code = C_Q;    ch = 8'h3F; end
    endcase
  end

  // Debounce and commit decision for the window closing on this edge
  always_comb begin
    stab_new = 3'd1;
    if (code == last_code_q)
      stab_new = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 3'd1;
    closing = run && (w_cnt_q == LAST_CYC);
    commit  = closing && (stab_new == STAB_MAX);
    chg     = commit && (code != C_IDLE) && ((ch != char_out_q) || !char_valid_q);
  end

  // Window position and per-neuron counters; dropping enable discards the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt_q <= '0;
      cnt_q   <= '0;
    end else if (!run || closing) begin
      w_cnt_q <= '0;
      cnt_q   <= '0;
    end else begin
      w_cnt_q <= w_cnt_q + 8'd1;
      cnt_q   <= cnt_inc;
    end
  end

  // Window result, debounce history and committed character
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_mask_q <= '0;
      last_code_q   <= C_IDLE;
      stab_q        <= '0;
      char_out_q    <= '0;
      char_valid_q  <= 1'b0;
    end else if (closing) begin
      active_mask_q <= mask;
      last_code_q   <= code;
      stab_q        <= stab_new;
      if (commit) begin
        if (code == C_IDLE) begin
          char_valid_q <= 1'b0;
        end else begin
          char_out_q   <= ch;
          char_valid_q <= 1'b1;
        end
      end
    end
  end

  // One-cycle strobes following a closing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_done_q     <= 1'b0;
      char_changed_q <= 1'b0;
    end else begin
      win_done_q     <= closing;
      char_changed_q <= chg;
    end
  end

  assign bus.char_out     = char_out_q;
  assign bus.char_valid   = char_valid_q;
  assign bus.char_changed = char_changed_q;
  assign bus.active_mask  = active_mask_q;
  assign bus.win_done     = win_done_q;

`ifdef SPIKE_DEC_STATS_EN
  logic [15:0] commit_cnt_q;

  // Count commits that change or revalidate the character, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      commit_cnt_q <= '0;
    else if (chg && (commit_cnt_q != 16'hFFFF))
      commit_cnt_q <= commit_cnt_q + 16'd1;
  end

  assign bus.commit_cnt = commit_cnt_q;
`endif

endmodule

// File: tb/tb_spike_char_decoder.sv
// tb_spike_char_decoder: table-driven and randomized checks of spike_char_decoder
// against a window-level reference model.
module tb_spike_char_decoder;

  localparam int WIN   = 16;
  localparam int SN    = 2;
  localparam int TH    = 4;
  localparam int CMAX  = 31;
  localparam int WIN_B = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spike_char_decoder_if bus_a ();
  spike_char_decoder_if bus_b ();

  spike_char_decoder #(.WIN_LEN(WIN), .CNT_W(5), .FIRE_TH(TH), .STABLE_N(SN)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));

  spike_char_decoder #(.WIN_LEN(WIN_B), .CNT_W(5), .FIRE_TH(TH), .STABLE_N(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: window sums, debounce history, committed character
  int         m_pos;
  int         m_sum [4];
  logic [7:0] m_last;
  int         m_stab;
  logic [7:0] m_char;
  logic       m_valid;
  logic [3:0] m_mask;
  logic       m_wd, m_chg;
  int         m_commits;

  function automatic logic [7:0] map_char(logic [3:0] m);
    case (m)
      4'b0000: return 8'h00;
      4'b0011: return 8'h41;
      4'b1100: return 8'h42;
      4'b0101: return 8'h43;
      4'b1010: return 8'h44;
      4'b1111: return 8'h58;
      default: return 8'h3F;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0;
    for (int i = 0; i < 4; i++) m_sum[i] = 0;
    m_last = 8'h00; m_stab = 0; m_char = 8'h00; m_valid = 1'b0;
    m_mask = 4'h0; m_wd = 1'b0; m_chg = 1'b0; m_commits = 0;
  endtask

  task automatic model_step(logic en, logic [3:0] s);
    logic [3:0] m;
    logic [7:0] c;
    m_wd  = 1'b0;
    m_chg = 1'b0;
    if (!en) begin
      m_pos = 0;
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) m_sum[i] += int'(s[i]);
    if (m_pos == WIN - 1) begin
      for (int i = 0; i < 4; i++) m[i] = ((m_sum[i] > CMAX ? CMAX : m_sum[i]) >= TH);
      c = map_char(m);
      m_stab = (c == m_last) ? ((m_stab + 1 > SN) ? SN : m_stab + 1) : 1;
      m_last = c;
      m_mask = m;
      m_wd   = 1'b1;
      if (m_stab == SN) begin
        if (c != 8'h00) begin
          if (c != m_char || !m_valid) begin
            m_chg = 1'b1;
            if (m_commits < 16'hFFFF) m_commits++;
          end
          m_char  = c;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pos = 0;
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_a();
    chk("char_out",     16'(bus_a.char_out),     16'(m_char));
    chk("char_valid",   16'(bus_a.char_valid),   16'(m_valid));
    chk("active_mask",  16'(bus_a.active_mask),  16'(m_mask));
    chk("win_done",     16'(bus_a.win_done),     16'(m_wd));
    chk("char_changed", 16'(bus_a.char_changed), 16'(m_chg));
`ifdef SPIKE_DEC_STATS_EN
    chk("commit_cnt",   bus_a.commit_cnt,        16'(m_commits));
`endif
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_char_out"},     16'(bus_a.char_out),     16'h0);
    chk({tag, "_char_valid"},   16'(bus_a.char_valid),   16'h0);
    chk({tag, "_char_changed"}, 16'(bus_a.char_changed), 16'h0);
    chk({tag, "_active_mask"},  16'(bus_a.active_mask),  16'h0);
    chk({tag, "_win_done"},     16'(bus_a.win_done),     16'h0);
`ifdef SPIKE_DEC_STATS_EN
    chk({tag, "_commit_cnt"},   bus_a.commit_cnt,        16'h0);
`endif
  endtask

  int wd_seen, chg_seen, b_chg_seen;

  task automatic tick(logic en, logic [3:0] s);
    bus_a.enable   = en;
    bus_a.spike_in = s;
    @(posedge clk);
    #1;
    model_step(en, s);
    check_a();
    if (bus_a.win_done)     wd_seen++;
    if (bus_a.char_changed) chg_seen++;
    if (bus_b.char_changed) b_chg_seen++;
  endtask

  typedef struct {
    logic [3:0] spk;
    int         n;
    logic [7:0] ch;
    logic       vld;
    logic [3:0] msk;
    int         wd;
    int         chg;
  } seg_t;

  seg_t segs [5];

  initial begin
    logic [3:0] tgt;
    logic [3:0] s;
    logic [3:0] pats [3];
    logic [7:0] exp_b [3];
    int drop_at;

    segs[0] = '{4'b0011, 32, 8'h41, 1'b1, 4'b0011, 2, 1};
    segs[1] = '{4'b1100, 16, 8'h41, 1'b1, 4'b1100, 1, 0};
    segs[2] = '{4'b1100, 16, 8'h42, 1'b1, 4'b1100, 1, 1};
    segs[3] = '{4'b1100, 16, 8'h42, 1'b1, 4'b1100, 1, 0};
    segs[4] = '{4'b0001, 32, 8'h3F, 1'b1, 4'b0001, 2, 1};

    bus_a.enable = 1'b0; bus_a.spike_in = 4'h0;
    bus_b.enable = 1'b0; bus_b.spike_in = 4'h0;
    model_reset();
    wd_seen = 0; chg_seen = 0; b_chg_seen = 0;

    #2 rst_n = 1'b0;
    #2 check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // steady patterns, commit latency and repeated-commit suppression
    foreach (segs[k]) begin
      wd_seen = 0; chg_seen = 0;
      repeat (segs[k].n) tick(1'b1, segs[k].spk);
      chk("seg_char",  16'(bus_a.char_out),    16'(segs[k].ch));
      chk("seg_valid", 16'(bus_a.char_valid),  16'(segs[k].vld));
      chk("seg_mask",  16'(bus_a.active_mask), 16'(segs[k].msk));
      chk("seg_wd",    16'(wd_seen),           16'(segs[k].wd));
      chk("seg_chg",   16'(chg_seen),          16'(segs[k].chg));
    end

    // three spikes per window: one below threshold, goes idle
    wd_seen = 0; chg_seen = 0;
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < WIN; c++)
        tick(1'b1, (c % 6 == 0) ? 4'b0011 : 4'b0000);
    chk("sub_mask",  16'(bus_a.active_mask), 16'h0);
    chk("sub_valid", 16'(bus_a.char_valid),  16'h0);
    chk("sub_char",  16'(bus_a.char_out),    16'h3F);
    chk("sub_chg",   16'(chg_seen),          16'h0);
    chk("sub_wd",    16'(wd_seen),           16'h2);

    // abort mid-window, re-enable
    repeat (10) tick(1'b1, 4'hF);
    wd_seen = 0;
    repeat (5) tick(1'b0, 4'hF);
    chk("abort_wd", 16'(wd_seen), 16'h0);
    for (int i = 1; i <= WIN; i++) tick(1'b1, 4'hF);
    chk("reen_wd_pulse", 16'(bus_a.win_done), 16'h1);
    chk("reen_wd_count", 16'(wd_seen),        16'h1);
    chg_seen = 0;
    repeat (WIN) tick(1'b1, 4'hF);
    chk("x_char",  16'(bus_a.char_out),   16'h58);
    chk("x_valid", 16'(bus_a.char_valid), 16'h1);
    chk("x_chg",   16'(chg_seen),         16'h1);

    // asynchronous reset mid-window with spikes active
    repeat (7) tick(1'b1, 4'hF);
    #2 rst_n = 1'b0;
    #1 check_zero("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wd_seen = 0;
    for (int i = 1; i <= WIN; i++) tick(1'b1, 4'hF);
    chk("rst_first_wd", 16'(bus_a.win_done), 16'h1);
    chk("rst_wd_count", 16'(wd_seen),        16'h1);

    // single-window debounce, saturation: 35 of 40 spikes must still count as active
    pats[0] = 4'b0011; pats[1] = 4'b0101; pats[2] = 4'b0011;
    exp_b[0] = 8'h41;  exp_b[1] = 8'h43;  exp_b[2] = 8'h41;
    for (int w = 0; w < 3; w++) begin
      b_chg_seen = 0;
      for (int c = 0; c < WIN_B; c++) begin
        bus_b.enable   = 1'b1;
        bus_b.spike_in = (c < 35) ? pats[w] : 4'b0000;
        tick(1'b0, 4'h0);
      end
      chk("b_char",  16'(bus_b.char_out),    16'(exp_b[w]));
      chk("b_valid", 16'(bus_b.char_valid),  16'h1);
      chk("b_mask",  16'(bus_b.active_mask), 16'(pats[w]));
      chk("b_chg",   16'(b_chg_seen),        16'h1);
    end
`ifdef SPIKE_DEC_STATS_EN
    chk("b_commit_cnt", bus_b.commit_cnt, 16'h3);
`endif
    bus_b.enable = 1'b0; bus_b.spike_in = 4'h0;

    // randomized windows, occasional aborts, checked cycle by cycle against the model
    tgt = 4'b0011;
    for (int w = 0; w < 60; w++) begin
      if ($urandom % 2 == 0) tgt = 4'($urandom % 16);
      drop_at = ($urandom % 8 == 0) ? int'($urandom_range(1, 15)) : -1;
      for (int c = 0; c < WIN; c++) begin
        if (c == drop_at) repeat ($urandom_range(1, 4)) tick(1'b0, 4'($urandom));
        for (int i = 0; i < 4; i++)
          s[i] = tgt[i] ? ($urandom % 4 != 0) : ($urandom % 8 == 0);
        tick(1'b1, s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
